// File: rtl/n_register_e_pkg.sv
// Shared constants for the enabled N-bit data register.
// Latency: none (constants only).
// Backpressure: none.
package n_register_e_pkg;

  // Default data width of the register.
  localparam int DEFAULT_WIDTH = 8;

  // Default value held while reset is asserted.
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

endpackage : n_register_e_pkg

// File: rtl/n_register_e_bit.sv
// Single enabled D flip-flop with async active-low clear to a per-bit value.
// Latency: one clock from d to q when enable is high.
// Backpressure: none; enable low simply holds the stored bit.
module n_register_e_bit
  import n_register_e_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic enable,
  output logic q
);

  // Reset wins over any clock edge; otherwise load on enable, else hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_BIT;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule : n_register_e_bit

// File: rtl/n_register_e.sv
// Generic WIDTH-bit data register with synchronous load enable and async clear.
// Latency: one clock from io_D to io_Q on an enabled edge; reset is immediate.
// Backpressure: none; io_enable low holds io_Q indefinitely.
module n_register_e
  import n_register_e_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_D,
  input  logic             io_enable,
  output logic [WIDTH-1:0] io_Q
);

  // One independent flop per bit; all share the same enable and clear, and
  // each bit clears to its own slice of RESET_VALUE.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    n_register_e_bit #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .d      (io_D[i]),
      .enable (io_enable),
      .q      (io_Q[i])
    );
  end

endmodule : n_register_e

// File: tb/tb_n_register_e.sv
// Directed bench for n_register_e: default 8-bit, 1-bit and 32-bit builds.
// Latency: outputs sampled on the falling edge after each loading edge.
// Backpressure: not applicable.
module tb_n_register_e;

  logic        clk;
  logic        reset;
  logic        io_enable;
  logic [7:0]  d8;
  logic [7:0]  q8;
  logic [0:0]  d1;
  logic [0:0]  q1;
  logic [31:0] d32;
  logic [31:0] q32;

  int checks;
  int failures;

  n_register_e u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .io_D      (d8),
    .io_enable (io_enable),
    .io_Q      (q8)
  );

  n_register_e #(
    .WIDTH (1)
  ) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .io_D      (d1),
    .io_enable (io_enable),
    .io_Q      (q1)
  );

  n_register_e #(
    .WIDTH       (32),
    .RESET_VALUE (32'hDEAD_BEEF)
  ) u_dut32 (
    .clk       (clk),
    .reset     (reset),
    .io_D      (d32),
    .io_enable (io_enable),
    .io_Q      (q32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    io_enable = 1'b1;
    d8        = 8'hA5;
    d1        = 1'b1;
    d32       = 32'h1234_5678;

    // Power-on reset, asserted with a real falling edge before any clock.
    #1 reset = 1'b0;
    #1;
    check("por_async_q8",  32'(q8), 32'h00);
    check("por_async_q32", q32, 32'hDEAD_BEEF);
    check("por_async_q1",  32'(q1), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("por_q8",  32'(q8), 32'h00);
      check("por_q32", q32, 32'hDEAD_BEEF);
      check("por_q1",  32'(q1), 32'h0);
    end

    // Release mid-cycle, then a single load.
    reset = 1'b1;
    d8    = 8'h3C;
    d32   = 32'hCAFE_F00D;
    d1    = 1'b1;
    step();
    check("load_q8",  32'(q8), 32'h3C);
    check("load_q32", q32, 32'hCAFE_F00D);
    check("load_q1",  32'(q1), 32'h1);

    // Hold for five edges with different data presented.
    io_enable = 1'b0;
    d8        = 8'hFF;
    d32       = 32'h0000_0000;
    d1        = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_q8",  32'(q8), 32'h3C);
      check("hold_q32", q32, 32'hCAFE_F00D);
      check("hold_q1",  32'(q1), 32'h1);
    end

    // Enable pulsed between edges must not load.
    #2 io_enable = 1'b1;
    #1 io_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("glitch_en_q8", 32'(q8), 32'h3C);

    // Back-to-back loads follow one cycle behind.
    io_enable = 1'b1;
    d8 = 8'h01; d32 = 32'h0000_0001; d1 = 1'b0;
    step();
    check("b2b0_q8",  32'(q8), 32'h01);
    check("b2b0_q32", q32, 32'h0000_0001);
    check("b2b0_q1",  32'(q1), 32'h0);
    d8 = 8'h80; d32 = 32'h8000_0000; d1 = 1'b1;
    step();
    check("b2b1_q8",  32'(q8), 32'h80);
    check("b2b1_q32", q32, 32'h8000_0000);
    check("b2b1_q1",  32'(q1), 32'h1);
    d8 = 8'hFF; d32 = 32'hFFFF_FFFF; d1 = 1'b0;
    step();
    check("b2b2_q8",  32'(q8), 32'hFF);
    check("b2b2_q32", q32, 32'hFFFF_FFFF);
    check("b2b2_q1",  32'(q1), 32'h0);

    // Async reset between edges takes effect before the next edge.
    d1 = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("midrst_q8",  32'(q8), 32'h00);
    check("midrst_q32", q32, 32'hDEAD_BEEF);
    check("midrst_q1",  32'(q1), 32'h0);
    // Enabled edges while reset is low: reset wins.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      step();
      check("rst_wins_q8",  32'(q8), 32'h00);
      check("rst_wins_q32", q32, 32'hDEAD_BEEF);
    end

    // Release and reload.
    reset = 1'b1;
    d8    = 8'h5A;
    d32   = 32'hA5A5_5A5A;
    d1    = 1'b1;
    step();
    check("reload_q8",  32'(q8), 32'h5A);
    check("reload_q32", q32, 32'hA5A5_5A5A);
    check("reload_q1",  32'(q1), 32'h1);

    // Final hold after reload.
    io_enable = 1'b0;
    d8 = 8'h00; d32 = 32'h0; d1 = 1'b0;
    step();
    check("final_hold_q8",  32'(q8), 32'h5A);
    check("final_hold_q32", q32, 32'hA5A5_5A5A);
    check("final_hold_q1",  32'(q1), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_n_register_e
